// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one unified memory port between the instruction-fetch path (i_*) and
// the load/store path (d_*). Each requester uses a level request held until a
// one-cycle done pulse. The memory side uses a valid/ready handshake
// (mem_req held until mem_ready). Data accesses win arbitration over fetch,
// but after D_STREAK_MAX back-to-back data grants with a fetch waiting, the
// fetch is granted so it cannot starve.
//
// Access timeline with zero wait states: request seen in IDLE at cycle N,
// mem_req at N+1, done at N+2, back in IDLE at N+3.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   i_req      fetch request (level)         i_addr   fetch address
//   i_done     fetch complete pulse          i_rdata  fetched word (held)
//   d_req      data request (level)          d_we     1 = store, 0 = load
//   d_addr     data address                  d_wdata  store data
//   d_done     data complete pulse           d_rdata  load data (held)
//   mem_req    memory request                mem_we   memory write enable
//   mem_addr   memory address                mem_wdata memory write data
//   mem_ready  memory completes access       mem_rdata memory read data
//   stall      combinational hold for PC / pipeline state
//   err        timeout flag, pulses with done
//
// Optional feature macro: MEM_TIMEOUT_EN
//   Defined:   an ACC cycle counter forces completion after TIMEOUT_CYC cycles
//              without mem_ready; done and err pulse together, rdata reads 0.
//   Undefined: accesses wait indefinitely and err is tied to 0.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int D_STREAK_MAX = 4,
    parameter int TIMEOUT_CYC  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              err
);

    localparam int STREAK_W = (D_STREAK_MAX < 1) ? 1 : $clog2(D_STREAK_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(D_STREAK_MAX);
    localparam logic [STREAK_W-1:0] STREAK_ONE   = STREAK_W'(1);
    localparam logic [STREAK_W-1:0] STREAK_ZERO  = STREAK_W'(0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC_I = 2'd1,
        ACC_D = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_r,     state_nx_s;
    logic [STREAK_W-1:0] streak_r,    streak_nx_s;
    logic                mem_req_r,   mem_req_nx_s;
    logic                mem_we_r,    mem_we_nx_s;
    logic [ADDR_W-1:0]   mem_addr_r,  mem_addr_nx_s;
    logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_nx_s;
    logic                i_done_r,    i_done_nx_s;
    logic                d_done_r,    d_done_nx_s;
    logic [DATA_W-1:0]   i_rdata_r,   i_rdata_nx_s;
    logic [DATA_W-1:0]   d_rdata_r,   d_rdata_nx_s;

    logic grant_d_s;
    logic grant_i_s;

`ifdef MEM_TIMEOUT_EN
    localparam int TIMER_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] TIMER_ZERO = TIMER_W'(0);

    logic [TIMER_W-1:0] timer_r, timer_nx_s;
    logic               err_r,   err_nx_s;
    logic               timeout_s;
`endif

    // Arbitration: data wins unless it has used up its streak while fetch waits.
    always_comb begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        if (d_req && (!i_req || (streak_r < STREAK_LIMIT))) begin
            grant_d_s = 1'b1;
        end else if (i_req) begin
            grant_i_s = 1'b1;
        end else begin
            grant_d_s = 1'b0;
            grant_i_s = 1'b0;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Timeout counter: counts ACC cycles, zero whenever the FSM is outside ACC
    // so it restarts on every ACC entry.
    always_comb begin
        timer_nx_s = TIMER_ZERO;
        timeout_s  = 1'b0;
        if ((state_r == ACC_I) || (state_r == ACC_D)) begin
            timer_nx_s = timer_r + TIMER_ONE;
            timeout_s  = (timer_r == TIMER_LAST);
        end else begin
            timer_nx_s = TIMER_ZERO;
            timeout_s  = 1'b0;
        end
    end
`endif

    // Access FSM next state and next values of every registered output.
    always_comb begin
        state_nx_s     = state_r;
        streak_nx_s    = streak_r;
        mem_req_nx_s   = mem_req_r;
        mem_we_nx_s    = mem_we_r;
        mem_addr_nx_s  = mem_addr_r;
        mem_wdata_nx_s = mem_wdata_r;
        i_done_nx_s    = 1'b0;
        d_done_nx_s    = 1'b0;
        i_rdata_nx_s   = i_rdata_r;
        d_rdata_nx_s   = d_rdata_r;
`ifdef MEM_TIMEOUT_EN
        err_nx_s       = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (grant_d_s) begin
                    state_nx_s     = ACC_D;
                    mem_req_nx_s   = 1'b1;
                    mem_we_nx_s    = d_we;
                    mem_addr_nx_s  = d_addr;
                    mem_wdata_nx_s = d_wdata;
                    // Streak only grows while a fetch is actually being held off.
                    if (i_req) begin
                        if (streak_r == STREAK_LIMIT) begin
                            streak_nx_s = streak_r;
                        end else begin
                            streak_nx_s = streak_r + STREAK_ONE;
                        end
                    end else begin
                        streak_nx_s = STREAK_ZERO;
                    end
                end else if (grant_i_s) begin
                    state_nx_s    = ACC_I;
                    mem_req_nx_s  = 1'b1;
                    mem_we_nx_s   = 1'b0;
                    mem_addr_nx_s = i_addr;
                    streak_nx_s   = STREAK_ZERO;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ACC_I, ACC_D: begin
                if (mem_ready) begin
                    state_nx_s   = RESP;
                    mem_req_nx_s = 1'b0;
                    if (state_r == ACC_D) begin
                        d_done_nx_s = 1'b1;
                        // Stores leave the last load value in place.
                        if (!mem_we_r) begin
                            d_rdata_nx_s = mem_rdata;
                        end else begin
                            d_rdata_nx_s = d_rdata_r;
                        end
                    end else begin
                        i_done_nx_s  = 1'b1;
                        i_rdata_nx_s = mem_rdata;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeout_s) begin
                    state_nx_s   = RESP;
                    mem_req_nx_s = 1'b0;
                    err_nx_s     = 1'b1;
                    if (state_r == ACC_D) begin
                        d_done_nx_s  = 1'b1;
                        d_rdata_nx_s = {DATA_W{1'b0}};
                    end else begin
                        i_done_nx_s  = 1'b1;
                        i_rdata_nx_s = {DATA_W{1'b0}};
                    end
                end
`endif
                else begin
                    state_nx_s = state_r;
                end
            end
            RESP: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s   = IDLE;
                mem_req_nx_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears any outstanding access at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            streak_r    <= STREAK_ZERO;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            i_done_r    <= 1'b0;
            d_done_r    <= 1'b0;
            i_rdata_r   <= {DATA_W{1'b0}};
            d_rdata_r   <= {DATA_W{1'b0}};
        end else begin
            state_r     <= state_nx_s;
            streak_r    <= streak_nx_s;
            mem_req_r   <= mem_req_nx_s;
            mem_we_r    <= mem_we_nx_s;
            mem_addr_r  <= mem_addr_nx_s;
            mem_wdata_r <= mem_wdata_nx_s;
            i_done_r    <= i_done_nx_s;
            d_done_r    <= d_done_nx_s;
            i_rdata_r   <= i_rdata_nx_s;
            d_rdata_r   <= d_rdata_nx_s;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Timeout counter and error flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_r <= TIMER_ZERO;
            err_r   <= 1'b0;
        end else begin
            timer_r <= timer_nx_s;
            err_r   <= err_nx_s;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign i_done    = i_done_r;
    assign d_done    = d_done_r;
    assign i_rdata   = i_rdata_r;
    assign d_rdata   = d_rdata_r;

    // The stall drops in the done cycle so the pipeline advances with the data.
    assign stall = (i_req & ~i_done_r) | (d_req & ~d_done_r);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. Single accesses come from a table
// of {request, memory behaviour, expected result} records; expected results
// go into a scoreboard queue when a request is driven and are compared when
// the matching done pulse appears. Hand-written sequences cover simultaneous
// requests, the data streak limit, reset mid-access and (with MEM_TIMEOUT_EN)
// the access timeout. Inputs are driven and outputs sampled on the falling
// edge; the DUT updates on the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        err;

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .D_STREAK_MAX(4),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_done   (i_done),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_done   (d_done),
        .d_rdata  (d_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .stall    (stall),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        int          waits;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [7];
    vec_t sb_q [$];
    bit   grant_q [$];

    int n_vec = 0;
    int n_mis = 0;
    logic [31:0] last_i = 32'h0;
    logic [31:0] last_d = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One single-requester access; called on a falling edge, returns on one.
    task automatic apply_vec(input vec_t v);
        int   cyc;
        int   acc;
        bit   seen;
        vec_t e;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        mem_rdata = v.mrdata;
        mem_ready = (v.waits == 0);  // ready outside ACC must be ignored
        sb_q.push_back(v);
        #1;
        check("stall_on_request", 32'(stall), 32'h1);
        cyc = 0; acc = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (mem_req) begin
                acc++;
                check("mem_addr", mem_addr, v.addr);
                check("mem_we", 32'(mem_we), 32'(v.is_d & v.we));
                if (v.is_d && v.we) check("mem_wdata", mem_wdata, v.wdata);
                check("stall_in_acc", 32'(stall), 32'h1);
                mem_ready = (acc > v.waits);
            end else if (i_done || d_done) begin
                seen = 1'b1;
                e = sb_q.pop_front();
                check("done_latency", 32'(cyc), 32'(e.waits + 2));
                check("i_done_sel", 32'(i_done), 32'(!e.is_d));
                check("d_done_sel", 32'(d_done), 32'(e.is_d));
                check("err_low", 32'(err), 32'h0);
                check("stall_at_done", 32'(stall), 32'h0);
                if (e.is_d) begin
                    check("d_rdata", d_rdata, e.exp_rdata);
                    check("i_rdata_hold", i_rdata, last_i);
                    last_d = e.exp_rdata;
                    d_req = 1'b0;
                end else begin
                    check("i_rdata", i_rdata, e.exp_rdata);
                    check("d_rdata_hold", d_rdata, last_d);
                    last_i = e.exp_rdata;
                    i_req = 1'b0;
                end
                mem_ready = 1'b0;
            end
        end
        if (!seen) begin
            check("done_timeout", 32'(cyc), 32'h0);
            i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
            sb_q.delete();
        end
        @(negedge clk);
        check("done_single_pulse", 32'({i_done, d_done}), 32'h0);
        check("mem_req_idle", 32'(mem_req), 32'h0);
    endtask

    initial begin
        int  cyc;
        int  grants;
        bit  seen;
        bit  eg;

        tbl[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         32'h0050_0093, 0, 32'h0050_0093};
        tbl[1] = '{1'b1, 1'b0, 32'h0000_2004, 32'h0,         32'h1234_5678, 0, 32'h1234_5678};
        tbl[2] = '{1'b1, 1'b1, 32'h0000_2008, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1, 32'h1234_5678};
        tbl[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,         32'h00A0_0113, 3, 32'h00A0_0113};
        tbl[4] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'hA5A5_A5A5, 2, 32'hA5A5_A5A5};
        tbl[5] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000, 0, 32'h0000_0000};
        tbl[6] = '{1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h5555_5555, 0, 32'hA5A5_A5A5};

        reset = 1'b0;
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        mem_ready = 1'b0; mem_rdata = 32'h0;

        // Reset values
        #12;
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_dones", 32'({i_done, d_done}), 32'h0);
        check("rst_i_rdata", i_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Table-driven single accesses
        for (int k = 0; k < 7; k++) apply_vec(tbl[k]);

        // Simultaneous store and fetch: data first, then fetch
        i_req = 1'b1; i_addr = 32'h0000_0100;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_2000; d_wdata = 32'hDEAD_BEEF;
        mem_ready = 1'b1; mem_rdata = 32'h1111_1111;
        grant_q.push_back(1'b1);
        grant_q.push_back(1'b0);
        seen = 1'b0; cyc = 0;
        while (!seen && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (mem_req) begin
                if (grant_q.size() == 0) begin
                    check("t2_extra_grant", mem_addr, 32'h0);
                end else begin
                    eg = grant_q.pop_front();
                    check("t2_grant_is_d", 32'(mem_addr == 32'h0000_2000), 32'(eg));
                    check("t2_mem_we", 32'(mem_we), 32'(eg));
                    if (eg) check("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
                    else    check("t2_fetch_addr", mem_addr, 32'h0000_0100);
                end
            end
            if (d_done) begin
                check("t2_store_keeps_d_rdata", d_rdata, last_d);
                d_req = 1'b0;
            end
            if (i_done) begin
                check("t2_i_rdata", i_rdata, 32'h1111_1111);
                last_i = 32'h1111_1111;
                i_req = 1'b0;
                seen = 1'b1;
            end
        end
        check("t2_all_grants_seen", 32'(grant_q.size()), 32'h0);
        check("t2_fetch_done_seen", 32'(seen), 32'h1);
        grant_q.delete();
        @(negedge clk);

        // Continuous contention: D,D,D,D,I,D,D,D,D,I
        for (int k = 0; k < 10; k++) grant_q.push_back((k % 5) != 4);
        i_req = 1'b1; i_addr = 32'h0000_0100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2000;
        mem_ready = 1'b1; mem_rdata = 32'h2222_2222;
        grants = 0; cyc = 0;
        while (grants < 10 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (mem_req) begin
                eg = grant_q.pop_front();
                check("t3_grant_order", 32'(mem_addr == 32'h0000_2000), 32'(eg));
                grants++;
                if (grants == 10) begin
                    // Dropping requests mid-access must not abort it
                    i_req = 1'b0; d_req = 1'b0;
                end
            end
        end
        check("t3_grant_count", 32'(grants), 32'd10);
        @(negedge clk);
        check("t3_done_after_drop", 32'(i_done), 32'h1);
        check("t3_i_rdata", i_rdata, 32'h2222_2222);
        last_i = 32'h2222_2222;
        last_d = 32'h2222_2222;
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t3_quiet_after", 32'(mem_req), 32'h0);

        // Reset during a data access
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_3000;
        mem_ready = 1'b0; mem_rdata = 32'h0BAD_CAFE;
        @(negedge clk);
        check("t5_acc_d", 32'(mem_req), 32'h1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t5_async_mem_req", 32'(mem_req), 32'h0);
        check("t5_async_mem_addr", mem_addr, 32'h0);
        check("t5_async_d_rdata", d_rdata, 32'h0);
        @(negedge clk);
        check("t5_no_done_in_reset", 32'({i_done, d_done}), 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("t5_reissue_req", 32'(mem_req), 32'h1);
        check("t5_reissue_addr", mem_addr, 32'h0000_3000);
        mem_ready = 1'b1;
        @(negedge clk);
        check("t5_d_done", 32'(d_done), 32'h1);
        check("t5_d_rdata", d_rdata, 32'h0BAD_CAFE);
        check("t5_i_rdata_reset", i_rdata, 32'h0);
        d_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);

`ifdef MEM_TIMEOUT_EN
        // Timeout: memory never answers a load
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_4000;
        mem_ready = 1'b0;
        grants = 0; seen = 1'b0; cyc = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (mem_req) grants++;
            if (d_done) begin
                seen = 1'b1;
                check("t6_err", 32'(err), 32'h1);
                check("t6_d_rdata_zero", d_rdata, 32'h0);
                check("t6_mem_req_low", 32'(mem_req), 32'h0);
                d_req = 1'b0;
            end
        end
        check("t6_acc_cycles", 32'(grants), 32'd8);
        check("t6_done_seen", 32'(seen), 32'h1);
        @(negedge clk);
        check("t6_err_pulse", 32'(err), 32'h0);
`else
        check("err_tied_low", 32'(err), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Sequences and shares a single unified memory port between the datapath's instruction-fetch path and its load/store path. Sits between the datapath and the external memory model. Runs a small access FSM with a level-request / done-pulse handshake per requester and a full valid/ready handshake to memory. Exports a stall to the control unit so the PC and pipeline state hold while an access is outstanding. Data accesses get priority over fetch, with a streak limit so fetch is never starved.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits
D_STREAK_MAX, 4, maximum consecutive data grants while a fetch is pending (must be ≥1)
TIMEOUT_CYC, 16, access-timeout limit in cycles; used only when MEM_TIMEOUT_EN is defined

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset (reset=0 resets)
i_req  in  1  fetch request; level, held until i_done
i_addr  in  ADDR_W  fetch address
i_done  out  1  one-cycle pulse, fetch complete
i_rdata  out  DATA_W  fetched word; valid with i_done, held until the next fetch completion
d_req  in  1  data request; level, held until d_done
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_done  out  1  one-cycle pulse, data access complete
d_rdata  out  DATA_W  load data; valid with d_done, held until the next data completion
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ready  in  1  memory accepts/completes the access this cycle
mem_rdata  in  DATA_W  read data, valid when mem_ready=1
stall  out  1  combinational: (i_req & ~i_done) | (d_req & ~d_done)
err  out  1  timeout flag, pulses with done; constant 0 without MEM_TIMEOUT_EN

Behaviour:
- Reset values (asynchronous, take effect immediately): state IDLE, streak counter 0, mem_req/mem_we 0, mem_addr/mem_wdata 0, i_done/d_done 0, i_rdata/d_rdata 0, err 0.
- States:
  - IDLE: arbitrate. Grant rule:
    - d_req=1 and (i_req=0 or streak<D_STREAK_MAX): grant data.
    - Otherwise i_req=1: grant fetch.
    - Neither: stay in IDLE.
  - ACC_I / ACC_D: mem_req=1, with addr/we/wdata registered at grant time. All held stable until mem_ready=1. Fetch always has mem_we=0.
  - RESP: one cycle. The owner's done=1. Rdata was registered from mem_rdata in the mem_ready cycle. No arbitration in RESP; go to IDLE next cycle.
- Transitions: IDLE→ACC_x on grant; ACC_x→RESP on mem_ready; RESP→IDLE.
- mem_req drops in the cycle after mem_ready (registered output).
- Latency: request seen in IDLE at cycle N → mem_req at N+1 → with zero wait states, done at N+2 → IDLE at N+3. Minimum 3 cycles per access. Each wait state adds 1 cycle.
- Streak counter:
  - Data grant with i_req=1: increment, saturating at D_STREAK_MAX.
  - Data grant with i_req=0: clear to 0.
  - Fetch grant: clear to 0.
- Requester inputs are sampled only at grant time. Dropping req or changing addr during ACC does not abort the access; done still pulses.
- Store completion: d_done pulses and d_rdata keeps its previous value.
- Async reset mid-access: mem_req deasserts immediately and no done pulse is generated. After release, requests still held are re-arbitrated from IDLE.
- mem_ready while not in ACC: ignored.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: a cycle counter runs in ACC_x and clears on state entry. If it reaches TIMEOUT_CYC with no mem_ready, the FSM goes to RESP, the owner's done and err pulse together, that rdata is forced to 0, and mem_req drops.
- Undefined: ACC_x waits indefinitely, err is tied to 0, and no timeout counter is present.

Test Plan:
1. mem_ready tied 1; i_req=1, i_addr=0x100, mem_rdata=0x00500093 → mem_req=1 with mem_addr=0x100 and mem_we=0 at cycle 1; i_done=1 with i_rdata=0x00500093 at cycle 2; stall=1 during cycles 0–1.
2. i_req and d_req (store, addr 0x2000, wdata 0xDEADBEEF) asserted in the same cycle → first access is mem_we=1, addr 0x2000, wdata 0xDEADBEEF; d_done pulses; next grant is fetch.
3. d_req and i_req held high continuously, D_STREAK_MAX=4 → grant order D,D,D,D,I,D,… with no fetch starvation.
4. mem_ready delayed 3 cycles → mem_req/mem_addr stable for 4 cycles; done exactly 1 cycle after mem_ready; mem_req low the cycle after mem_ready.
5. reset driven low during ACC_D → mem_req=0 immediately, no d_done; after release with d_req still high → access re-issued from IDLE.
6. With MEM_TIMEOUT_EN and TIMEOUT_CYC=8; d_req load, mem_ready never asserted → after 8 ACC cycles, d_done=1, err=1, d_rdata=0; then IDLE.
